// File: rtl/uart_tx_ctrl_if.sv
// ---------------------------------------------------------------------------------------------
// uart_tx_ctrl_if: handshake and mux-control bundle between a word source and uart_tx_ctrl.
//
// Signals (direction as seen by the slave, i.e. the transmit controller):
//   p_data     in   DATA_WIDTH  parallel word to transmit
//   data_valid in   1           p_data valid; taken only while busy is low
//   par_en     in   1           1 = append a parity bit after the data bits
//   par_typ    in   1           0 = even parity, 1 = odd parity
//   mux_sel    out  2           TX mux select: 00 start, 01 data, 10 parity, 11 stop/idle
//   ser_data   out  1           current serialized data bit (used when mux_sel = 01)
//   par_bit    out  1           parity of the latched word (used when mux_sel = 10)
//   busy       out  1           high while a frame is in flight
// ---------------------------------------------------------------------------------------------
interface uart_tx_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_typ;
    logic [1:0]            mux_sel;
    logic                  ser_data;
    logic                  par_bit;
    logic                  busy;

    // Word source side.
    modport master (
        output p_data,
        output data_valid,
        output par_en,
        output par_typ,
        input  mux_sel,
        input  ser_data,
        input  par_bit,
        input  busy
    );

    // Transmit controller side.
    modport slave (
        input  p_data,
        input  data_valid,
        input  par_en,
        input  par_typ,
        output mux_sel,
        output ser_data,
        output par_bit,
        output busy
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------------------------
// uart_tx_ctrl: UART transmit controller (frame FSM, serializer, parity generator).
//
// One CLK period is one bit period. A word is accepted from the interface when the controller
// is idle and data_valid is high; the frame then runs start, DATA_WIDTH data bits (LSB first),
// an optional parity bit and one stop bit. The controller only steers the downstream TX mux;
// it never drives the line itself.
//
// Ports:
//   CLK    in   bit-rate clock, all state changes on the rising edge
//   RST    in   synchronous active-high reset
//   tx_if  slave modport of uart_tx_ctrl_if (p_data/data_valid/par_en/par_typ in,
//                                            mux_sel/ser_data/par_bit/busy out)
//
// All outputs come straight from flops; mux_sel and busy are decoded from the next state so
// they line up with the state register.
// ---------------------------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic          CLK,
    input  logic          RST,
    uart_tx_ctrl_if.slave tx_if
);

    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
        $error("uart_tx_ctrl: DATA_WIDTH must be in 5..9");
    end

    localparam int unsigned CntW = $clog2(DATA_WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

    // TX mux select encodings.
    localparam logic [1:0] SelStart  = 2'b00;
    localparam logic [1:0] SelData   = 2'b01;
    localparam logic [1:0] SelParity = 2'b10;
    localparam logic [1:0] SelIdle   = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                state_q,    state_d;
    logic [CntW-1:0]       cnt_q,      cnt_d;
    logic [DATA_WIDTH-1:0] shift_q,    shift_d;
    logic                  par_en_q,   par_en_d;
    logic                  ser_data_q, ser_data_d;
    logic                  par_bit_q,  par_bit_d;
    logic [1:0]            mux_sel_q,  mux_sel_d;
    logic                  busy_q,     busy_d;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        ser_data_d = ser_data_q;
        par_bit_d  = par_bit_q;

        unique case (state_q)
            StIdle: begin
                if (tx_if.data_valid) begin
                    state_d   = StStart;
                    shift_d   = tx_if.p_data;
                    par_en_d  = tx_if.par_en;
                    // Parity is taken from the word as it is accepted, not from shift_q.
                    par_bit_d = (^tx_if.p_data) ^ tx_if.par_typ;
                end
            end
            StStart: begin
                // Present bit 0 on the first DATA cycle.
                state_d    = StData;
                ser_data_d = shift_q[0];
                shift_d    = shift_q >> 1;
                cnt_d      = '0;
            end
            StData: begin
                if (cnt_q == LastBit) begin
                    cnt_d   = '0;
                    state_d = par_en_q ? StParity : StStop;
                end else begin
                    cnt_d      = cnt_q + CntW'(1);
                    ser_data_d = shift_q[0];
                    shift_d    = shift_q >> 1;
                end
            end
            StParity: begin
                state_d = StStop;
            end
            StStop: begin
                // Always drops to IDLE, guaranteeing one idle bit between frames.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        mux_sel_d = SelIdle;
        busy_d    = 1'b0;
        unique case (state_d)
            StIdle: begin
                mux_sel_d = SelIdle;
                busy_d    = 1'b0;
            end
            StStart: begin
                mux_sel_d = SelStart;
                busy_d    = 1'b1;
            end
            StData: begin
                mux_sel_d = SelData;
                busy_d    = 1'b1;
            end
            StParity: begin
                mux_sel_d = SelParity;
                busy_d    = 1'b1;
            end
            StStop: begin
                mux_sel_d = SelIdle;
                busy_d    = 1'b1;
            end
            default: begin
                mux_sel_d = SelIdle;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset wins over any coincident data_valid.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            ser_data_q <= 1'b0;
            par_bit_q  <= 1'b0;
            mux_sel_q  <= SelIdle;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            ser_data_q <= ser_data_d;
            par_bit_q  <= par_bit_d;
            mux_sel_q  <= mux_sel_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_if.mux_sel  = mux_sel_q;
    assign tx_if.ser_data = ser_data_q;
    assign tx_if.par_bit  = par_bit_q;
    assign tx_if.busy     = busy_q;

endmodule
